prefetch_rd_arb: RTL and testbench
==================================

PREFETCH_RD_ARB -- requirements
Module: prefetch_rd_arb

Interface
REQ-001 Parameter N_CH, default 4: number of prefetch-FIFO read ports arbitrated (2..8).
REQ-002 Parameter DW, default 16: data width per channel.
REQ-003 Parameter LEN_W, default 8: burst-length field width.
REQ-004 rd_clk  in  1  single clock; all logic on its rising edge.
REQ-005 rd_rst  in  1  reset, asynchronous assert, active-high.
REQ-006 ch_en  in  N_CH  per-channel arbitration enable.
REQ-007 ch_rd_data  in  N_CH*DW  channel data, channel i in bits [i*DW +: DW].
REQ-008 ch_rd_vld  in  N_CH  channel head-word valid (prefetch FIFO rd_vld).
REQ-009 ch_rd_en  out  N_CH  channel pop (prefetch FIFO rd_en).
REQ-010 cfg_burst_len  in  LEN_W  beats per burst; 0 means 2^LEN_W.
REQ-011 cfg_idle_max  in  4  consecutive starved cycles before burst abort; 0 disables abort.
REQ-012 out_data  out  DW  merged stream data.
REQ-013 out_vld  out  1  out_data valid.
REQ-014 out_ready  in  1  downstream accept.
REQ-015 out_ch  out  clog2(N_CH)  channel index of current burst.
REQ-016 out_sof / out_eof  out  1 each  first / last beat of a full burst, qualified by out_vld.
REQ-017 burst_abort  out  1  one-cycle pulse when a burst is terminated by starvation.
REQ-018 busy  out  1  high in GRANT or XFER.

Function
REQ-019 States IDLE, GRANT, XFER; IDLE->GRANT when any (ch_en & ch_rd_vld) bit set; GRANT->XFER unconditionally after one cycle; XFER->IDLE on last beat accepted or on abort.
REQ-020 In IDLE, grant SHALL be registered to the first requesting channel searching upward (mod N_CH) from last_grant+1; last_grant resets to N_CH-1, so channel 0 wins first.
REQ-021 cfg_burst_len SHALL be latched on IDLE->GRANT; changes mid-burst have no effect.
REQ-022 In XFER: out_vld = ch_rd_vld[g], out_data = channel g data, ch_rd_en[g] = out_ready; all other ch_rd_en bits 0; ch_rd_en is 0 outside XFER.
REQ-023 A beat transfers when out_vld & out_ready; beat counter (LEN_W+1 bits) increments per beat, cleared on GRANT.
REQ-024 out_sof high on beat counter 0; out_eof high when counter = latched length-1; length 0 gives 2^LEN_W beats with counter wrap not permitted before eof.
REQ-025 Starvation counter increments each XFER cycle with ch_rd_vld[g]=0, clears on any valid cycle; reaching cfg_idle_max (non-zero) SHALL pulse burst_abort and return to IDLE with no eof.
REQ-026 out_ready low SHALL stall without counting starvation while out_vld high.
REQ-027 ch_en[g] deasserting mid-burst SHALL NOT terminate the burst; it only excludes g from the next arbitration.
REQ-028 Arbitration latency: first beat may appear 2 cycles after request seen in IDLE; back-to-back bursts incur one IDLE and one GRANT cycle.

Reset
REQ-029 On rd_rst: state IDLE, last_grant N_CH-1, counters 0, out_vld/out_sof/out_eof/burst_abort/busy/ch_rd_en 0, out_ch 0, out_data 0.
REQ-030 Reset mid-burst SHALL drop the burst immediately; no beat popped in the reset cycle.

Structure
REQ-031 Shared package holds state encoding and the LEN_W/idle-counter width constants.
REQ-032 Round-robin selection SHALL be one sub-module rr_arb (request vector, last grant in; one-hot grant, index, any_req out), purely combinational.

Verification
REQ-033 Channels 0..3 all valid, len=4, out_ready=1 -> bursts in order 0,1,2,3,0, each 4 beats, sof on beat 0, eof on beat 3.
REQ-034 Only channel 2 requests, len=0, LEN_W=8 -> exactly 256 beats, eof on beat 255, no abort.
REQ-035 Channel 1 vld drops after beat 2, idle_max=3, len=8 -> burst_abort on the 3rd starved cycle, no eof, next grant channel 2.
REQ-036 out_ready toggles 1/0 per cycle, len=4 -> 4 beats over 8 cycles, no abort, ch_rd_en tracks out_ready.
REQ-037 rd_rst asserted on beat 2 of a burst -> all outputs 0 next edge, after release channel 0 granted first.
REQ-038 cfg_burst_len changed 4->2 mid-burst -> current burst 4 beats, following burst 2 beats.

Source files
------------

// File: rtl/prefetch_rd_arb_pkg.sv
// Shared state encoding and width constants for the prefetch read arbiter.
package prefetch_rd_arb_pkg;

    localparam int LEN_W_DEF = 8;
    localparam int IDLE_W    = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_XFER  = 2'd2
    } arb_state_t;

endpackage

// File: rtl/prefetch_rd_arb_if.sv
// Channel-side prefetch FIFO read ports plus the merged output stream.
interface prefetch_rd_arb_if #(
    parameter int N_CH = 4,
    parameter int DW   = 16
);

    logic [N_CH-1:0]          ch_en;
    logic [N_CH*DW-1:0]       ch_rd_data;
    logic [N_CH-1:0]          ch_rd_vld;
    logic [N_CH-1:0]          ch_rd_en;
    logic [DW-1:0]            out_data;
    logic                     out_vld;
    logic                     out_ready;
    logic [$clog2(N_CH)-1:0]  out_ch;
    logic                     out_sof;
    logic                     out_eof;

    modport master (
        input  ch_en, ch_rd_data, ch_rd_vld, out_ready,
        output ch_rd_en, out_data, out_vld, out_ch, out_sof, out_eof
    );

    modport slave (
        output ch_en, ch_rd_data, ch_rd_vld, out_ready,
        input  ch_rd_en, out_data, out_vld, out_ch, out_sof, out_eof
    );

endinterface

// File: rtl/prefetch_rd_arb_rr_arb.sv
// Combinational round-robin picker: first request searching upward from last_grant+1.
module rr_arb #(
    parameter int N_CH = 4
) (
    input  logic [N_CH-1:0]         req,
    input  logic [$clog2(N_CH)-1:0] last_grant,
    output logic [N_CH-1:0]         gnt,
    output logic [$clog2(N_CH)-1:0] gnt_idx,
    output logic                    any_req
);

    localparam int IDX_W = $clog2(N_CH);

    logic [IDX_W-1:0] cand;
    logic             found;

    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        found   = 1'b0;
        cand    = '0;
        for (int k = 1; k <= N_CH; k++) begin
            cand = IDX_W'((int'(last_grant) + k) % N_CH);
            if (!found && req[cand]) begin
                found        = 1'b1;
                gnt[cand]    = 1'b1;
                gnt_idx      = cand;
            end
        end
    end

    assign any_req = |req;

endmodule

// File: rtl/prefetch_rd_arb.sv
// Round-robin burst arbiter merging N_CH prefetch FIFO read ports into one stream.
//  state | meaning
//  IDLE  | no burst; round-robin picks the next requesting channel
//  GRANT | channel and burst length latched, counters cleared
//  XFER  | beats streamed from the granted channel until eof or starvation abort
module prefetch_rd_arb
    import prefetch_rd_arb_pkg::*;
#(
    parameter int N_CH  = 4,
    parameter int DW    = 16,
    parameter int LEN_W = LEN_W_DEF
) (
    input  logic               rd_clk,
    input  logic               rd_rst,
    prefetch_rd_arb_if.master  bus,
    input  logic [LEN_W-1:0]   cfg_burst_len,
    input  logic [IDLE_W-1:0]  cfg_idle_max,
    output logic               burst_abort,
    output logic               busy
);

    localparam int IDX_W = $clog2(N_CH);
    localparam logic [LEN_W:0]    BEAT_ONE   = (LEN_W+1)'(1);
    localparam logic [IDLE_W-1:0] STARVE_ONE = IDLE_W'(1);

    arb_state_t         state, state_nxt;
    logic [IDX_W-1:0]   last_grant;
    logic [IDX_W-1:0]   gnt_idx;
    logic [N_CH-1:0]    gnt_oh;
    logic [LEN_W-1:0]   len_q;
    logic [LEN_W:0]     beat_cnt;
    logic [LEN_W:0]     last_beat;
    logic [IDLE_W-1:0]  starve_cnt;

    logic [N_CH-1:0]    req_vec;
    logic [N_CH-1:0]    arb_gnt;
    logic [IDX_W-1:0]   arb_idx;
    logic               any_req;

    logic               g_vld;
    logic [DW-1:0]      g_data;
    logic               beat;
    logic               eof_c;
    logic               abort_c;

    assign req_vec = bus.ch_en & bus.ch_rd_vld;

    rr_arb #(.N_CH(N_CH)) u_rr_arb (
        .req        (req_vec),
        .last_grant (last_grant),
        .gnt        (arb_gnt),
        .gnt_idx    (arb_idx),
        .any_req    (any_req)
    );

    // Length 0 encodes a full 2^LEN_W burst; the extra counter bit keeps it from wrapping.
    assign last_beat = (len_q == '0) ? {1'b0, {LEN_W{1'b1}}} : ({1'b0, len_q} - BEAT_ONE);

    assign g_vld = |(bus.ch_rd_vld & gnt_oh);

    always_comb begin
        g_data = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (gnt_oh[i]) g_data = g_data | bus.ch_rd_data[i*DW +: DW];
        end
    end

    always_ff @(posedge rd_clk or posedge rd_rst) begin
        if (rd_rst) begin
            state      <= ST_IDLE;
            last_grant <= IDX_W'(N_CH-1);
            gnt_idx    <= '0;
            gnt_oh     <= '0;
            len_q      <= '0;
            beat_cnt   <= '0;
            starve_cnt <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                ST_IDLE: begin
                    if (any_req) begin
                        gnt_idx    <= arb_idx;
                        gnt_oh     <= arb_gnt;
                        last_grant <= arb_idx;
                        len_q      <= cfg_burst_len;
                    end
                end
                ST_GRANT: begin
                    beat_cnt   <= '0;
                    starve_cnt <= '0;
                end
                ST_XFER: begin
                    if (beat) beat_cnt <= beat_cnt + BEAT_ONE;
                    if (g_vld)
                        starve_cnt <= '0;
                    else if (starve_cnt != '1)
                        starve_cnt <= starve_cnt + STARVE_ONE;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_nxt    = state;
        bus.out_vld  = 1'b0;
        bus.out_data = '0;
        bus.ch_rd_en = '0;
        bus.out_sof  = 1'b0;
        bus.out_eof  = 1'b0;
        beat         = 1'b0;
        eof_c        = 1'b0;
        abort_c      = 1'b0;
        case (state)
            ST_IDLE: begin
                if (any_req) state_nxt = ST_GRANT;
            end
            ST_GRANT: begin
                state_nxt = ST_XFER;
            end
            ST_XFER: begin
                eof_c        = g_vld && (beat_cnt == last_beat);
                beat         = g_vld && bus.out_ready;
                // Stalls with data present never count toward starvation.
                abort_c      = !g_vld && (cfg_idle_max != '0) &&
                               (starve_cnt == cfg_idle_max - STARVE_ONE);
                bus.out_vld  = g_vld;
                bus.out_data = g_data;
                bus.ch_rd_en = bus.out_ready ? gnt_oh : '0;
                bus.out_sof  = g_vld && (beat_cnt == '0);
                bus.out_eof  = eof_c;
                if ((eof_c && bus.out_ready) || abort_c) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    assign bus.out_ch  = gnt_idx;
    assign burst_abort = abort_c;
    assign busy        = (state != ST_IDLE);

endmodule

// File: tb/tb_prefetch_rd_arb.sv
// Self-checking bench for prefetch_rd_arb: vector table, directed bursts, random vs. model.
module tb_prefetch_rd_arb;
    import prefetch_rd_arb_pkg::*;

    localparam int N_CH  = 4;
    localparam int DW    = 16;
    localparam int LEN_W = 8;

    logic              rd_clk = 1'b0;
    logic              rd_rst;
    logic [LEN_W-1:0]  cfg_burst_len;
    logic [IDLE_W-1:0] cfg_idle_max;
    logic              burst_abort;
    logic              busy;

    int checks = 0;
    int errors = 0;

    prefetch_rd_arb_if #(.N_CH(N_CH), .DW(DW)) bus ();

    prefetch_rd_arb #(.N_CH(N_CH), .DW(DW), .LEN_W(LEN_W)) dut (
        .rd_clk        (rd_clk),
        .rd_rst        (rd_rst),
        .bus           (bus),
        .cfg_burst_len (cfg_burst_len),
        .cfg_idle_max  (cfg_idle_max),
        .burst_abort   (burst_abort),
        .busy          (busy)
    );

    always #5 rd_clk = ~rd_clk;

    typedef struct packed {
        logic        rst;
        logic [3:0]  en;
        logic [3:0]  vld;
        logic        rdy;
        logic [7:0]  len;
        logic [3:0]  idle;
        logic [10:0] exp;   // {busy, out_vld, out_ch, sof, eof, abort, ch_rd_en}
    } vec_t;

    vec_t tbl [11];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic setup(input logic [3:0] en, input logic [3:0] vld, input logic rdy,
                         input logic [7:0] len, input logic [3:0] idle);
        bus.ch_en     = en;
        bus.ch_rd_vld = vld;
        bus.out_ready = rdy;
        cfg_burst_len = len;
        cfg_idle_max  = idle;
    endtask

    task automatic do_reset();
        rd_rst = 1'b1;
        bus.ch_rd_data = {16'h3333, 16'h2222, 16'h1111, 16'h0000};
        setup(4'h0, 4'h0, 1'b0, 8'd4, 4'd0);
        repeat (2) @(negedge rd_clk);
        rd_rst = 1'b0;
    endtask

    // Follows one burst from the idle gap through eof-accepted or abort.
    task automatic collect(input int drop_after, input bit tog_ready, input int len_after,
                           input logic [7:0] new_len, input int budget,
                           output int ch, output int beats, output int sof_at, output int eof_at,
                           output int xfer_cyc, output int lead, output bit aborted,
                           output bit en_ok, output bit done);
        ch = -1; beats = 0; sof_at = -1; eof_at = -1; xfer_cyc = 0; lead = 0;
        aborted = 1'b0; en_ok = 1'b1; done = 1'b0;
        for (int c = 0; c < budget && !done; c++) begin
            @(negedge rd_clk);
            if (ch >= 0 && drop_after >= 0 && beats >= drop_after) bus.ch_rd_vld[ch] = 1'b0;
            if (ch >= 0 && len_after >= 0 && beats >= len_after) cfg_burst_len = new_len;
            if (tog_ready) bus.out_ready = (xfer_cyc % 2 == 1);
            #1;
            if (ch < 0 && bus.out_vld) ch = int'(bus.out_ch);
            if (ch < 0) lead++;
            else begin
                xfer_cyc++;
                if (bus.ch_rd_en !== (bus.out_ready ? 4'(1 << ch) : 4'd0)) en_ok = 1'b0;
                if (bus.out_sof) sof_at = beats;
                if (bus.out_eof) eof_at = beats;
                if (burst_abort) begin aborted = 1'b1; done = 1'b1; end
                if (bus.out_vld && bus.out_ready) begin
                    beats++;
                    if (bus.out_eof) done = 1'b1;
                end
            end
        end
    endtask

    int  r_ch, r_beats, r_sof, r_eof, r_xc, r_lead;
    bit  r_ab, r_enok, r_done;

    int  m_phase, m_ch, m_last, m_len, m_beats, m_starve;
    logic [3:0]      en_v, vld_v, e_en, req;
    logic            rdy_v, e_vld, e_sof, e_eof, e_abort;
    logic [7:0]      len_v;
    logic [3:0]      idle_v;
    logic [63:0]     data_v;
    logic [DW-1:0]   e_data;
    logic [31:0]     ra, rb;
    int              nb;
    bit              hit;

    initial begin
        tbl[0]  = '{1'b1, 4'h0, 4'h0, 1'b0, 8'd2, 4'd2, 11'b0_0_00_0_0_0_0000};
        tbl[1]  = '{1'b0, 4'h8, 4'h8, 1'b1, 8'd2, 4'd2, 11'b0_0_00_0_0_0_0000};
        tbl[2]  = '{1'b0, 4'h8, 4'h8, 1'b1, 8'd2, 4'd2, 11'b1_0_11_0_0_0_0000};
        tbl[3]  = '{1'b0, 4'h8, 4'h8, 1'b1, 8'd5, 4'd2, 11'b1_1_11_1_0_0_1000};
        tbl[4]  = '{1'b0, 4'h8, 4'h8, 1'b0, 8'd2, 4'd2, 11'b1_1_11_0_1_0_0000};
        tbl[5]  = '{1'b0, 4'h8, 4'h8, 1'b1, 8'd2, 4'd2, 11'b1_1_11_0_1_0_1000};
        tbl[6]  = '{1'b0, 4'h9, 4'h9, 1'b1, 8'd2, 4'd2, 11'b0_0_11_0_0_0_0000};
        tbl[7]  = '{1'b0, 4'h9, 4'h9, 1'b1, 8'd1, 4'd2, 11'b1_0_00_0_0_0_0000};
        tbl[8]  = '{1'b0, 4'h9, 4'h8, 1'b1, 8'd1, 4'd2, 11'b1_0_00_0_0_0_0001};
        tbl[9]  = '{1'b0, 4'h9, 4'h8, 1'b1, 8'd1, 4'd2, 11'b1_0_00_0_0_1_0001};
        tbl[10] = '{1'b0, 4'h0, 4'h0, 1'b1, 8'd2, 4'd2, 11'b0_0_00_0_0_0_0000};

        rd_rst = 1'b1;
        bus.ch_rd_data = '0;
        setup(4'h0, 4'h0, 1'b0, 8'd0, 4'd0);

        for (int i = 0; i < 11; i++) begin
            @(negedge rd_clk);
            rd_rst = tbl[i].rst;
            setup(tbl[i].en, tbl[i].vld, tbl[i].rdy, tbl[i].len, tbl[i].idle);
            #1;
            chk($sformatf("vec%0d", i),
                {busy, bus.out_vld, bus.out_ch, bus.out_sof, bus.out_eof, burst_abort, bus.ch_rd_en},
                tbl[i].exp);
        end

        // Four channels always valid: strict rotation, 4-beat bursts, one IDLE + one GRANT gap.
        do_reset();
        setup(4'hF, 4'hF, 1'b1, 8'd4, 4'd0);
        for (int b = 0; b < 5; b++) begin
            collect(-1, 1'b0, -1, 8'd0, 40, r_ch, r_beats, r_sof, r_eof, r_xc, r_lead, r_ab, r_enok, r_done);
            chk($sformatf("rr_ch%0d", b), r_ch, b % 4);
            chk($sformatf("rr_beats%0d", b), r_beats, 4);
            chk($sformatf("rr_sof%0d", b), r_sof, 0);
            chk($sformatf("rr_eof%0d", b), r_eof, 3);
            chk($sformatf("rr_ab%0d", b), r_ab, 0);
            if (b > 0) chk($sformatf("rr_gap%0d", b), r_lead, 2);
        end

        // Length 0 means a full 256-beat burst.
        do_reset();
        setup(4'h4, 4'h4, 1'b1, 8'd0, 4'd0);
        collect(-1, 1'b0, -1, 8'd0, 400, r_ch, r_beats, r_sof, r_eof, r_xc, r_lead, r_ab, r_enok, r_done);
        chk("len0_done", r_done, 1);
        chk("len0_ch", r_ch, 2);
        chk("len0_beats", r_beats, 256);
        chk("len0_eof", r_eof, 255);
        chk("len0_ab", r_ab, 0);

        // Channel 1 starves after three beats; abort on the third starved cycle.
        do_reset();
        setup(4'h6, 4'h6, 1'b1, 8'd8, 4'd3);
        collect(3, 1'b0, -1, 8'd0, 40, r_ch, r_beats, r_sof, r_eof, r_xc, r_lead, r_ab, r_enok, r_done);
        chk("starve_ch", r_ch, 1);
        chk("starve_beats", r_beats, 3);
        chk("starve_ab", r_ab, 1);
        chk("starve_noeof", r_eof, -1);
        chk("starve_cycles", r_xc, 6);
        collect(-1, 1'b0, -1, 8'd0, 40, r_ch, r_beats, r_sof, r_eof, r_xc, r_lead, r_ab, r_enok, r_done);
        chk("starve_next_ch", r_ch, 2);

        // Ready toggling: 4 beats across 8 XFER cycles, pops follow ready.
        do_reset();
        setup(4'h1, 4'h1, 1'b0, 8'd4, 4'd2);
        collect(-1, 1'b1, -1, 8'd0, 40, r_ch, r_beats, r_sof, r_eof, r_xc, r_lead, r_ab, r_enok, r_done);
        chk("tog_beats", r_beats, 4);
        chk("tog_cycles", r_xc, 8);
        chk("tog_ab", r_ab, 0);
        chk("tog_en", r_enok, 1);
        chk("tog_eof", r_eof, 3);

        // Length reprogrammed mid-burst applies only to the next burst.
        do_reset();
        setup(4'h1, 4'h1, 1'b1, 8'd4, 4'd0);
        collect(-1, 1'b0, 1, 8'd2, 40, r_ch, r_beats, r_sof, r_eof, r_xc, r_lead, r_ab, r_enok, r_done);
        chk("lenchg_cur", r_beats, 4);
        collect(-1, 1'b0, -1, 8'd0, 40, r_ch, r_beats, r_sof, r_eof, r_xc, r_lead, r_ab, r_enok, r_done);
        chk("lenchg_next", r_beats, 2);
        chk("lenchg_eof", r_eof, 1);

        // Reset landing on beat 2 of a burst.
        do_reset();
        setup(4'hF, 4'hF, 1'b1, 8'd4, 4'd0);
        nb = 0; hit = 1'b0;
        for (int c = 0; c < 20 && !hit; c++) begin
            @(negedge rd_clk); #1;
            if (bus.out_vld) begin
                if (nb == 2) hit = 1'b1;
                else nb++;
            end
        end
        chk("rst_reach", hit, 1);
        rd_rst = 1'b1;
        #1;
        chk("rst_async", {busy, bus.out_vld, bus.out_sof, bus.out_eof, burst_abort,
                          bus.ch_rd_en, bus.out_ch, bus.out_data}, 64'd0);
        @(posedge rd_clk); #1;
        chk("rst_edge", {busy, bus.out_vld, bus.out_sof, bus.out_eof, burst_abort,
                         bus.ch_rd_en, bus.out_ch, bus.out_data}, 64'd0);
        @(negedge rd_clk);
        rd_rst = 1'b0;
        collect(-1, 1'b0, -1, 8'd0, 40, r_ch, r_beats, r_sof, r_eof, r_xc, r_lead, r_ab, r_enok, r_done);
        chk("rst_first_ch", r_ch, 0);
        chk("rst_first_beats", r_beats, 4);

        // Random traffic against a burst-level reference model.
        do_reset();
        m_phase = 0; m_ch = 0; m_last = N_CH - 1; m_len = 0; m_beats = 0; m_starve = 0;
        for (int cyc = 0; cyc < 1500; cyc++) begin
            @(negedge rd_clk);
            ra = $urandom; rb = $urandom;
            en_v   = ra[3:0] | ra[7:4];
            vld_v  = rb[3:0] | rb[7:4];
            rdy_v  = (ra[9:8] != 2'b00);
            len_v  = 8'($urandom_range(1, 5));
            idle_v = 4'($urandom_range(0, 4));
            data_v = {$urandom, $urandom};
            setup(en_v, vld_v, rdy_v, len_v, idle_v);
            bus.ch_rd_data = data_v;
            #1;
            e_vld = 1'b0; e_sof = 1'b0; e_eof = 1'b0; e_abort = 1'b0; e_en = 4'd0; e_data = '0;
            if (m_phase == 2) begin
                e_vld   = vld_v[m_ch];
                e_data  = data_v[m_ch*DW +: DW];
                e_en    = rdy_v ? 4'(1 << m_ch) : 4'd0;
                e_sof   = e_vld && (m_beats == 0);
                e_eof   = e_vld && (m_beats == m_len - 1);
                e_abort = !e_vld && (idle_v != 0) && (m_starve + 1 == int'(idle_v));
            end
            chk($sformatf("rand_c%0d", cyc),
                {busy, bus.out_vld, bus.out_ch, bus.out_sof, bus.out_eof, burst_abort,
                 bus.ch_rd_en, bus.out_data},
                {(m_phase != 0), e_vld, 2'(m_ch), e_sof, e_eof, e_abort, e_en, e_data});
            case (m_phase)
                0: begin
                    req = en_v & vld_v;
                    if (req != 0) begin
                        for (int k = N_CH; k >= 1; k--) begin
                            if (req[(m_last + k) % N_CH]) m_ch = (m_last + k) % N_CH;
                        end
                        m_last  = m_ch;
                        m_len   = (len_v == 0) ? 256 : int'(len_v);
                        m_phase = 1;
                    end
                end
                1: begin
                    m_phase = 2; m_beats = 0; m_starve = 0;
                end
                default: begin
                    if (e_vld) m_starve = 0;
                    else m_starve++;
                    if (e_vld && rdy_v) begin
                        m_beats++;
                        if (m_beats == m_len) m_phase = 0;
                    end
                    if (e_abort) m_phase = 0;
                end
            endcase
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
